// File: rtl/inst_fetch_pkg.sv
// Shared widths, fetch FSM encoding and PC helper for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int REG_W       = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'd0,
    FETCH_WAIT_MEM = 2'd1,
    FETCH_DISCARD  = 2'd2
  } fetch_state_e;

  // Sequential PC step; wraps modulo 2^32 by construction.
  function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one word per line: combinational lookup, synchronous fill.
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int  ENTRIES = 32,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = INST_ADDR_W - 2 - IDX_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [REG_W-1:0] rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [REG_W-1:0] wr_data
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [REG_W-1:0]   data_q [ENTRIES];

  // Only the valid bits need clearing; tag/data are don't-care until a fill.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, miss FSM toward the memory controller and a one-entry decode slot.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                     ICACHE_ENTRIES = 32,
  parameter logic [INST_ADDR_W-1:0] RESET_PC       = 32'h0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   stall_in,
  input  logic                   jump_in,
  input  logic [INST_ADDR_W-1:0] jump_addr_in,
  input  logic [1:0]             busy_in,
  input  logic                   inst_done_in,
  input  logic [REG_W-1:0]       inst_in,
  output logic                   if_req_out,
  output logic [INST_ADDR_W-1:0] inst_addr_out,
  output logic                   if_valid_out,
  output logic [INST_ADDR_W-1:0] if_pc_out,
  output logic [REG_W-1:0]       if_inst_out
);

  localparam int IDX_W = $clog2(ICACHE_ENTRIES);
  localparam int TAG_W = INST_ADDR_W - 2 - IDX_W;

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic                   req_d;
  logic [INST_ADDR_W-1:0] addr_d;
  logic                   vld_d;
  logic [INST_ADDR_W-1:0] slot_pc_d;
  logic [REG_W-1:0]       slot_inst_d;
  logic                   slot_free;
  logic                   cache_hit;
  logic [REG_W-1:0]       cache_data;
  logic                   cache_we;

  // The fetch-ownership flag is not needed here; only data-side ownership blocks a new request.
  logic unused_busy_fetch;
  assign unused_busy_fetch = busy_in[1];

  inst_fetch_icache #(
    .ENTRIES (ICACHE_ENTRIES)
  ) u_icache (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (pc_q[2 +: IDX_W]),
    .rd_tag  (pc_q[INST_ADDR_W-1 -: TAG_W]),
    .hit     (cache_hit),
    .rd_data (cache_data),
    .we      (cache_we),
    .wr_idx  (inst_addr_out[2 +: IDX_W]),
    .wr_tag  (inst_addr_out[INST_ADDR_W-1 -: TAG_W]),
    .wr_data (inst_in)
  );

  assign slot_free = !if_valid_out || !stall_in;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = if_req_out;
    addr_d      = inst_addr_out;
    vld_d       = if_valid_out;
    slot_pc_d   = if_pc_out;
    slot_inst_d = if_inst_out;
    cache_we    = 1'b0;

    if (rdy_in) begin
      if (slot_free) begin
        vld_d = 1'b0;
      end

      unique case (state_q)
        FETCH_IDLE: begin
          if (!jump_in) begin
            if (cache_hit) begin
              if (slot_free) begin
                vld_d       = 1'b1;
                slot_pc_d   = pc_q;
                slot_inst_d = cache_data;
                pc_d        = next_pc(pc_q);
              end
            end else if (!busy_in[0]) begin
              req_d   = 1'b1;
              addr_d  = pc_q;
              state_d = FETCH_WAIT_MEM;
            end
          end
        end
        FETCH_WAIT_MEM, FETCH_DISCARD: begin
          // A transfer in flight always completes and fills; a redirect only marks it stale.
          if (jump_in) begin
            state_d = FETCH_DISCARD;
          end
          if (inst_done_in) begin
            cache_we = 1'b1;
            req_d    = 1'b0;
            state_d  = FETCH_IDLE;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase

      if (jump_in) begin
        vld_d = 1'b0;
        pc_d  = jump_addr_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      if_req_out    <= 1'b0;
      inst_addr_out <= '0;
      if_valid_out  <= 1'b0;
      if_pc_out     <= '0;
      if_inst_out   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_req_out    <= req_d;
      inst_addr_out <= addr_d;
      if_valid_out  <= vld_d;
      if_pc_out     <= slot_pc_d;
      if_inst_out   <= slot_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a memory-controller responder and a slot scoreboard.
module tb_inst_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        stall_in;
  logic        jump_in;
  logic [31:0] jump_addr_in;
  logic [1:0]  busy_in;
  logic        inst_done_in;
  logic [31:0] inst_in;
  logic        if_req_out;
  logic [31:0] inst_addr_out;
  logic        if_valid_out;
  logic [31:0] if_pc_out;
  logic [31:0] if_inst_out;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  slot_t sb[$];
  int    total = 0;
  int    bad   = 0;

  inst_fetch #(
    .ICACHE_ENTRIES (32),
    .RESET_PC       (32'h0)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .stall_in      (stall_in),
    .jump_in       (jump_in),
    .jump_addr_in  (jump_addr_in),
    .busy_in       (busy_in),
    .inst_done_in  (inst_done_in),
    .inst_in       (inst_in),
    .if_req_out    (if_req_out),
    .inst_addr_out (inst_addr_out),
    .if_valid_out  (if_valid_out),
    .if_pc_out     (if_pc_out),
    .if_inst_out   (if_inst_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00100113;
      32'h8:   return 32'h00208193;
      32'hC:   return 32'h00000013;
      default: return 32'hA0000000 | {16'h0, a[15:0]};
    endcase
  endfunction

  function automatic slot_t mk(input logic [31:0] pc, input logic [31:0] inst);
    slot_t s;
    s.pc   = pc;
    s.inst = inst;
    return s;
  endfunction

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!if_req_out && n < 200) begin
      tick(1);
      n++;
    end
    if (!if_req_out) begin
      total++;
      bad++;
      $display("FAIL %s: if_req_out still 0 after 200 cycles, want 1", name);
    end
  endtask

  task automatic wait_slot(input string name, input logic [31:0] pc);
    int n;
    n = 0;
    while (!(if_valid_out && if_pc_out == pc) && n < 200) begin
      tick(1);
      n++;
    end
    if (!(if_valid_out && if_pc_out == pc)) begin
      total++;
      bad++;
      $display("FAIL %s: slot pc %h valid %0d after 200 cycles, want pc %h", name, if_pc_out, if_valid_out, pc);
    end
  endtask

  task automatic pulse_jump(input logic [31:0] addr);
    jump_addr_in = addr;
    jump_in      = 1'b1;
    tick(1);
    jump_in      = 1'b0;
  endtask

  // Memory controller: answers each request four cycles after it is first seen.
  initial begin
    int cnt;
    cnt          = 0;
    inst_done_in = 1'b0;
    inst_in      = '0;
    forever begin
      @(posedge clk_in);
      #1;
      inst_done_in = 1'b0;
      if (if_req_out && rst_in) begin
        if (cnt == 3) begin
          inst_done_in = 1'b1;
          inst_in      = mem_word(inst_addr_out);
          cnt          = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Decode side: a slot is taken whenever it is valid, unstalled and the pipe is ready.
  initial begin
    slot_t e;
    forever begin
      @(negedge clk_in);
      if (rst_in && rdy_in && if_valid_out && !stall_in) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL slot_unexpected: got pc %h inst %h, want no slot", if_pc_out, if_inst_out);
        end else begin
          e = sb.pop_front();
          check("slot_pc", if_pc_out, e.pc);
          check("slot_inst", if_inst_out, e.inst);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    stall_in     = 1'b0;
    jump_in      = 1'b0;
    jump_addr_in = '0;
    busy_in      = 2'b00;

    tick(2);
    check("rst_req", 32'(if_req_out), 0);
    check("rst_addr", inst_addr_out, 0);
    check("rst_valid", 32'(if_valid_out), 0);
    check("rst_pc", if_pc_out, 0);
    check("rst_inst", if_inst_out, 0);

    // Cold start: every word comes through the memory controller.
    sb.push_back(mk(32'h0, 32'h00500093));
    sb.push_back(mk(32'h4, 32'h00100113));
    sb.push_back(mk(32'h8, 32'h00208193));
    sb.push_back(mk(32'hC, 32'h00000013));
    rst_in = 1'b1;
    wait_req("cold_req");
    n = 0;
    while (if_req_out && n < 20) begin
      check("cold_addr", inst_addr_out, 32'h0);
      n++;
      tick(1);
    end
    check("cold_req_cycles", 32'(n), 4);
    wait_slot("cold_slot_c", 32'hC);

    // Cached loop back to 0: one instruction per cycle, then a 3-cycle stall on pc 8.
    sb.push_back(mk(32'h0, 32'h00500093));
    sb.push_back(mk(32'h4, 32'h00100113));
    sb.push_back(mk(32'h8, 32'h00208193));
    sb.push_back(mk(32'hC, 32'h00000013));
    pulse_jump(32'h0);
    check("loop_flush", 32'(if_valid_out), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("loop_valid", 32'(if_valid_out), 1);
      check("loop_pc", if_pc_out, 32'(i * 4));
    end
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_pc", if_pc_out, 32'h8);
      check("stall_valid", 32'(if_valid_out), 1);
      check("stall_req", 32'(if_req_out), 0);
    end
    stall_in = 1'b0;
    wait_slot("stall_resume", 32'hC);

    // Redirect while a miss is outstanding: the fill completes, its word is never issued.
    sb.push_back(mk(32'h100, 32'hA0000100));
    pulse_jump(32'h20);
    wait_req("discard_req");
    check("discard_addr0", inst_addr_out, 32'h20);
    pulse_jump(32'h100);
    n = 0;
    while (if_req_out && n < 20) begin
      check("discard_addr", inst_addr_out, 32'h20);
      n++;
      tick(1);
    end
    check("discard_req_cycles", 32'(n), 3);
    wait_slot("discard_target", 32'h100);

    // The discarded line must now hit without a request.
    sb.push_back(mk(32'h20, 32'hA0000020));
    pulse_jump(32'h20);
    check("refhit_flush", 32'(if_valid_out), 0);
    tick(1);
    check("refhit_valid", 32'(if_valid_out), 1);
    check("refhit_pc", if_pc_out, 32'h20);
    check("refhit_req", 32'(if_req_out), 0);

    // Data-side ownership blocks a miss request.
    sb.push_back(mk(32'h40, 32'hA0000040));
    busy_in = 2'b01;
    pulse_jump(32'h40);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("busy_req", 32'(if_req_out), 0);
    end
    busy_in = 2'b00;
    tick(1);
    check("busy_release_req", 32'(if_req_out), 1);
    check("busy_release_addr", inst_addr_out, 32'h40);
    wait_slot("busy_slot", 32'h40);

    // PC wrap: the word after 0xFFFFFFFC is fetched from address 0.
    sb.push_back(mk(32'hFFFFFFFC, 32'hA000FFFC));
    sb.push_back(mk(32'h0, 32'h00500093));
    pulse_jump(32'hFFFFFFFC);
    wait_req("top_req");
    check("top_addr", inst_addr_out, 32'hFFFFFFFC);
    wait_slot("top_slot", 32'hFFFFFFFC);
    wait_req("wrap_req");
    check("wrap_addr", inst_addr_out, 32'h0);
    wait_slot("wrap_slot", 32'h0);

    // Reset in the middle of a miss.
    pulse_jump(32'h44);
    wait_req("mid_req");
    check("mid_addr", inst_addr_out, 32'h44);
    tick(1);
    rst_in = 1'b0;
    #1;
    check("midrst_req", 32'(if_req_out), 0);
    check("midrst_addr", inst_addr_out, 0);
    check("midrst_valid", 32'(if_valid_out), 0);
    check("midrst_pc", if_pc_out, 0);
    check("midrst_inst", if_inst_out, 0);
    tick(2);
    sb.push_back(mk(32'h0, 32'h00500093));
    rst_in = 1'b1;
    tick(1);
    check("postrst_req", 32'(if_req_out), 1);
    check("postrst_addr", inst_addr_out, 32'h0);
    check("postrst_valid", 32'(if_valid_out), 0);
    wait_slot("postrst_slot", 32'h0);

    // Global not-ready freezes everything.
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rdy_valid", 32'(if_valid_out), 1);
      check("rdy_pc", if_pc_out, 32'h0);
      check("rdy_inst", if_inst_out, 32'h00500093);
      check("rdy_req", 32'(if_req_out), 0);
    end
    rdy_in = 1'b1;
    pulse_jump(32'h20);
    rdy_in = 1'b0;
    tick(2);
    check("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter ICACHE_ENTRIES, default 32, meaning the number of direct-mapped icache lines (power of two, one word per line).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning the fetch address after reset.
REQ-003 SHALL have clk_in  input  1  meaning the single clock; all state changes on its posedge.
REQ-004 SHALL have rst_in  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have rdy_in  input  1  meaning global ready; when 0 all state holds.
REQ-006 SHALL have stall_in  input  1  meaning downstream decode cannot accept this cycle.
REQ-007 SHALL have jump_in  input  1  meaning redirect request, single-cycle pulse.
REQ-008 SHALL have jump_addr_in  input  32  meaning the redirect target PC.
REQ-009 SHALL have busy_in  input  2  meaning the memory-controller ownership flags; bit1 = fetch, bit0 = data.
REQ-010 SHALL have inst_done_in  input  1  meaning the memory controller word-fetch complete, single-cycle.
REQ-011 SHALL have inst_in  input  32  meaning the fetched word, valid with inst_done_in.
REQ-012 SHALL have if_req_out  output  1  meaning the fetch request to the memory controller.
REQ-013 SHALL have inst_addr_out  output  32  meaning the fetch address.
REQ-014 SHALL have if_valid_out  output  1  meaning the decode slot holds an instruction.
REQ-015 SHALL have if_pc_out  output  32  meaning the PC of the slot.
REQ-016 SHALL have if_inst_out  output  32  meaning the instruction of the slot.

Function
REQ-017 SHALL keep a fetch PC register; index = pc[2+IDX-1:2], tag = pc[31:2+IDX], IDX = log2(ICACHE_ENTRIES); pc[1:0] ignored.
REQ-018 SHALL implement FSM IDLE, WAIT_MEM, DISCARD.
REQ-019 IDLE on hit with slot free (slot empty, or slot valid && !stall_in): the next cycle SHALL load the slot with {pc, cached word}, set if_valid_out=1, pc<=pc+4; a hit therefore has one-cycle latency and a sustained hit rate of one instruction per cycle.
REQ-020 IDLE on miss with busy_in[0]==0: the next cycle SHALL assert if_req_out=1 with inst_addr_out=pc and enter WAIT_MEM; while busy_in[0]==1 it SHALL wait in IDLE with if_req_out=0.
REQ-021 WAIT_MEM SHALL hold if_req_out=1 and inst_addr_out stable until inst_done_in.
REQ-022 On inst_done_in in WAIT_MEM, the next cycle SHALL:
- write the word and tag into the cache and mark the line valid;
- deassert if_req_out;
- return to IDLE, where the refetch hits.
REQ-023 If jump_in is asserted in WAIT_MEM, the block SHALL enter DISCARD, keep if_req_out=1 until inst_done_in (transfers are never aborted), fill the cache, then go to IDLE with pc=jump_addr_in.
REQ-024 jump_in SHALL flush the slot (if_valid_out=0 next cycle) and set pc<=jump_addr_in, overriding stall_in and any same-cycle hit.
REQ-025 With slot valid and stall_in=1, if_valid_out, if_pc_out and if_inst_out SHALL hold unchanged and pc SHALL not advance.
REQ-026 inst_done_in outside WAIT_MEM/DISCARD SHALL be ignored.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h0).
REQ-028 With rdy_in=0, all registers including the cache SHALL hold; the outputs SHALL keep their current values.

Reset
REQ-029 rst_in=0 SHALL asynchronously force:
- pc=RESET_PC, FSM=IDLE;
- every cache valid bit=0;
- if_req_out=0, inst_addr_out=0;
- if_valid_out=0, if_pc_out=0, if_inst_out=0.
REQ-030 Reset asserted mid-miss SHALL abandon the transfer; after release, the block SHALL refetch RESET_PC from miss.

Structure
REQ-031 Address/data widths (InstAddrBus, RegBus) and the FSM state encodings SHALL live in the shared defines.v.
REQ-032 Cache storage SHALL be one sub-module, icache: tag/valid/data arrays with a combinational lookup and a synchronous write port; inst_fetch holds the FSM and PC.

Verification
REQ-033 Reset, then cache cold, RESET_PC=0; inst_done_in after 4 cycles with 32'h00500093 -> if_req_out=1 with inst_addr_out=0 until done; slot {pc=0, inst=32'h00500093}; pc=4.
REQ-034 Loop 0x0-0xC preloaded, no stall -> after fill, if_valid_out=1 every cycle with PCs 0,4,8,C,0 (jump_in to 0 at C).
REQ-035 stall_in=1 for 3 cycles with slot {pc=8} -> slot unchanged, no new if_req_out, and pc=0xC resumes after release.
REQ-036 jump_in to 0x100 during WAIT_MEM for 0x20 -> if_req_out stays 1 until done, line 0x20 filled and not issued, and the next slot pc=0x100.
REQ-037 Miss while busy_in=2'b01 for 5 cycles -> if_req_out=0 for those cycles, then 1 with inst_addr_out=pc.
REQ-038 rst_in=0 in WAIT_MEM -> if_req_out=0 immediately; all valid bits cleared; the first hit only occurs after refill.
